// File: rtl/seven_segment_pkg.sv
// Shared types, constants and the 7-segment decode table
// for the seven-segment scan controller.
package seven_segment_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BIN_W      = 32;
    localparam int ACC_W      = 40;

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_COMMIT
    } state_e;

    // Active-low segments, index 0 = a ... index 6 = g
    function automatic logic [0:6] seg_decode(input bcd_t d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: 32-bit binary to 10 BCD
// nibbles, one add-3/shift step per clock.
module bin2bcd_serial
    import seven_segment_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             bcd_valid,
    output logic [0:ACC_W-1] bcd
);

    logic [BIN_W-1:0] sreg_q, sreg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] adj;
    logic [4:0]       cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             vld_q, vld_d;
    logic             unused_adj_msb;

    // Nibbles >= 5 would overflow a decimal digit when doubled
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < ACC_W / 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, otherwise shift one binary bit in per cycle
    always_comb begin
        sreg_d = sreg_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        vld_d  = 1'b0;
        if (start) begin
            sreg_d = bin;
            acc_d  = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            acc_d  = {adj[ACC_W-2:0], sreg_q[BIN_W-1]};
            sreg_d = {sreg_q[BIN_W-2:0], 1'b0};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_d = 1'b0;
                vld_d = 1'b1;
            end
        end
    end

    // Converter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            vld_q  <= vld_d;
        end
    end

    // busy drops during the final shift so the caller can step to commit
    assign busy      = run_q && (cnt_q != 5'd31);
    assign bcd_valid = vld_q;
    assign bcd       = acc_q;

    // Top nibble can never reach 5 for a 32-bit input
    assign unused_adj_msb = adj[ACC_W-1];

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Accepts a binary number, converts it to BCD and scans it
// across 8 common-anode digits through one shared decoder.
module seven_segment_scan_controller
    import seven_segment_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:31] in_number,
    output logic        done,
    output logic [0:6]  seg_n,
    output logic [7:0]  digit_en_n
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    state_e                  state_q, state_d;
    bcd_t [NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [PW-1:0]           pre_q, pre_d;
    logic [2:0]              idx_q, idx_d;
    logic [0:6]              seg_q, seg_d;
    logic [7:0]              en_q, en_d;
    logic [NUM_DIGITS-1:0]   lit;
    logic                    seen;
    logic                    start;
    logic                    busy;
    logic                    bcd_valid;
    logic [ACC_W-1:0]        bcd_w;
    logic                    unused_bcd_hi;

    assign in_ready = !rst && (state_q == ST_IDLE);
    assign start    = in_valid && in_ready;
    assign done     = (state_q == ST_COMMIT);

    bin2bcd_serial u_conv (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (in_number),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd       (bcd_w)
    );

    // Conversion sequencing: accept, wait for the engine, commit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_CONVERT;
            ST_CONVERT: if (!busy) state_d = ST_COMMIT;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Shadow digits only change when a finished result is committed
    always_comb begin
        shadow_d = shadow_q;
        if (bcd_valid) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_d[i] = bcd_w[4*i +: 4];
            end
        end
    end

    // Prescaler paces the scan; index wraps naturally after digit 7
    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Leading-zero blanking and the single shared segment decoder
    always_comb begin
        seen = 1'b0;
        lit  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (shadow_q[i] != 4'd0) seen = 1'b1;
            lit[i] = seen || (i == 0) || !BLANK_LZ;
        end
        en_d  = ~(8'd1 << idx_q);
        seg_d = lit[idx_q] ? seg_decode(shadow_q[idx_q]) : SEG_OFF;
    end

    // State, display and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            en_q     <= 8'hFF;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            en_q     <= en_d;
        end
    end

    assign seg_n      = seg_q;
    assign digit_en_n = en_q;

    // Only value mod 10^8 is displayed
    assign unused_bcd_hi = ^bcd_w[ACC_W-1:4*NUM_DIGITS];

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: two instances
// (SCAN_DIV=4 blanked, SCAN_DIV=1 unblanked) against a model.
module tb_seven_segment_scan_controller;

    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [0:31] in_number = '0;
    logic        rdy0, rdy1, done0, done1;
    logic [0:6]  seg0, seg1;
    logic [7:0]  en0, en1;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                             7'b0000110, 7'b1001100, 7'b0100100,
                             7'b0100000, 7'b0001111, 7'b0000000,
                             7'b0001100};

    int div_k [2] = '{4, 1};
    bit blk_k [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    seven_segment_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_number(in_number), .done(done0), .seg_n(seg0),
        .digit_en_n(en0)
    );

    seven_segment_scan_controller #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_number(in_number), .done(done1), .seg_n(seg1),
        .digit_en_n(en1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected segments for digit i of value v, from decimal arithmetic
    function automatic logic [6:0] exp_seg(input int unsigned v,
                                           input int i, input bit blk);
        longint p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        if (blk && i > 0 && longint'(v) < p) return OFF;
        return tbl[int'((longint'(v) / p) % 10)];
    endfunction

    function automatic logic [6:0] code_seg(input logic [3:0] c);
        if (c == 4'hF) return OFF;
        return tbl[c];
    endfunction

    // Behavioural model: cycles since accept, shown value, scan position
    int unsigned m_t = 0, m_num = 0, m_shown = 0;
    int          m_idx [2];
    int          m_pre [2];
    logic [6:0]  m_seg [2];
    logic [7:0]  m_en  [2];
    bit          armed = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_en[k] = 8'hFF; m_seg[k] = OFF;
                m_idx[k] = 0;    m_pre[k] = 0;
            end else begin
                m_en[k]  = ~(8'd1 << m_idx[k]);
                m_seg[k] = exp_seg(m_shown, m_idx[k], blk_k[k]);
                if (m_pre[k] == div_k[k] - 1) begin
                    m_pre[k] = 0;
                    m_idx[k] = (m_idx[k] + 1) % 8;
                end else begin
                    m_pre[k]++;
                end
            end
        end
        if (rst) begin
            m_t = 0; m_shown = 0; armed = 1'b1;
        end else if (m_t == 33) begin
            m_shown = m_num % 100000000; m_t = 0;
        end else if (m_t > 0) begin
            m_t++;
        end else if (in_valid) begin
            m_num = in_number; m_t = 1;
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready0", {31'd0, rdy0}, {31'd0, !rst && m_t == 0});
            chk("in_ready1", {31'd0, rdy1}, {31'd0, !rst && m_t == 0});
            chk("done0", {31'd0, done0}, {31'd0, m_t == 33});
            chk("done1", {31'd0, done1}, {31'd0, m_t == 33});
            chk("seg0", {25'd0, seg0}, {25'd0, m_seg[0]});
            chk("seg1", {25'd0, seg1}, {25'd0, m_seg[1]});
            chk("en0", {24'd0, en0}, {24'd0, m_en[0]});
            chk("en1", {24'd0, en1}, {24'd0, m_en[1]});
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic accept(input logic [31:0] n);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_number = n;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = rdy0;
            @(posedge clk); #2;
        end
        chk("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input string nm, input int want);
        int t = 0;
        bit seen = 1'b0;
        while (t < 60 && !seen) begin
            @(negedge clk);
            t++;
            seen = done0;
        end
        @(posedge clk); #2;
        chk(nm, t, want);
    endtask

    task automatic send(input string nm, input logic [31:0] n);
        accept(n);
        in_valid = 1'b0;
        wait_done(nm, 33);
    endtask

    // One full scan; c = digit codes 7..0, nibble F = blank
    task automatic show_check(input string nm, input logic [31:0] c0,
                              input logic [31:0] c1);
        logic [6:0] cap0 [8];
        logic [6:0] cap1 [8];
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            cap0[i] = 'x; cap1[i] = 'x;
        end
        repeat (34) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (en0 == ~(8'd1 << i)) cap0[i] = seg0;
                if (en1 == ~(8'd1 << i)) cap1[i] = seg1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_a_d%0d", nm, i), {25'd0, cap0[i]},
                {25'd0, code_seg(c0[4*i +: 4])});
            chk($sformatf("%s_b_d%0d", nm, i), {25'd0, cap1[i]},
                {25'd0, code_seg(c1[4*i +: 4])});
        end
        @(posedge clk); #2;
    endtask

    initial begin
        int nd;
        logic [31:0] r;

        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_seg", {25'd0, seg0}, {25'd0, OFF});
        chk("rst_en", {24'd0, en0}, 32'h0000_00FF);
        chk("rst_rdy", {31'd0, rdy0}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_seg", {25'd0, seg0}, {25'd0, OFF});
        chk("post_rst_en", {24'd0, en0}, 32'h0000_00FF);
        @(posedge clk); #2;
        show_check("idle", 32'hFFFF_FFF0, 32'h0000_0000);

        send("lat_12345678", 32'd12345678);
        show_check("n12345678", 32'h1234_5678, 32'h1234_5678);

        send("lat_max", 32'hFFFF_FFFF);
        show_check("nmax", 32'h9496_7295, 32'h9496_7295);

        send("lat_1000", 32'd1000);
        show_check("n1000", 32'hFFFF_1000, 32'h0000_1000);

        accept(32'd7);
        in_number = 32'd9;
        @(negedge clk);
        chk("b2b_busy", {31'd0, rdy0}, 32'd0);
        @(posedge clk); #2;
        wait_done("b2b_first", 32);
        tick();
        in_valid = 1'b0;
        wait_done("b2b_second", 33);
        show_check("n9", 32'hFFFF_FFF9, 32'h0000_0009);

        accept(32'd55555555);
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_seg", {25'd0, seg0}, {25'd0, OFF});
        chk("abort_en", {24'd0, en0}, 32'h0000_00FF);
        @(posedge clk); #2;
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            nd += int'(done0);
        end
        chk("abort_no_done", nd, 0);
        @(posedge clk); #2;
        show_check("abort", 32'hFFFF_FFF0, 32'h0000_0000);
        send("lat_42", 32'd42);
        show_check("n42", 32'hFFFF_FF42, 32'h0000_0042);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 4)) tick();
            r = $urandom;
            if (it % 5 == 0) r = r % 1000;
            accept(r);
            in_valid = 1'($urandom_range(0, 1));
            in_number = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 30)) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                in_valid = 1'b0;
            end
            repeat (20) tick();
            in_valid = 1'b0;
            repeat (20) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
